uart_tx_mmio: RTL
=================

Name: uart_tx_mmio

Overview:
- MMIO responder implementing the transmit half of the SoC UART. It sits behind the mmio_if master port of the SoC interconnect in the UART_BASE 4 KB window.
- Accepts 32-bit register reads and writes, buffers bytes in a TX FIFO and serializes them 8N1 (LSB first) on the tx pin using a programmable baud divider.
- Presents a status register for software polling.

Parameters:
- ADDR_W, 12, width of mmio_addr (offset within the peripheral window).
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2 to 64.
- DIV_RESET, 16'd868, reset value of BAUDDIV (115200 baud at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, active-low.
- mmio_valid  in  1  request strobe, single cycle per transfer.
- mmio_we  in  1  1 = write, 0 = read; qualified by mmio_valid.
- mmio_addr  in  ADDR_W  byte offset.
- mmio_wdata  in  32  write data.
- mmio_wstrb  in  4  byte enables.
- mmio_ready  out  1  responder can accept a request.
- mmio_rdata  out  32  read data, valid the cycle after the read request.
- uart_tx  out  1  serial output, idle high.
- tx_irq  out  1  level interrupt: IRQ_EN & tx_empty & ~tx_busy.

Behaviour:
- Interface decision: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset state: mmio_ready=1, mmio_rdata=0, uart_tx=1, tx_irq=0, FIFO empty, serializer IDLE, BAUDDIV=DIV_RESET, CTRL=0, OVF=0.
- mmio_ready is constant 1 out of reset and never depends on mmio_valid, because the master gates valid with ready combinationally.
- Decode: addr[1:0] is ignored. Offsets with addr[ADDR_W-1:4] != 0 read 0; writes to them are ignored.
- Register map:
  - 0x0 TXDATA: write with wstrb[0]=1 pushes wdata[7:0]; reads 0.
  - 0x4 STATUS (read-only except OVF):
    - bit0 tx_full, bit1 tx_empty, bit2 tx_busy (serializer not IDLE), bit3 OVF (sticky, write-1-to-clear via wstrb[0]).
    - bits[15:8] FIFO count, zero-extended.
  - 0x8 BAUDDIV: RW bits[15:0], per-byte strobes. An effective divisor of 0 is treated as 1.
  - 0xC CTRL: bit0 TX_EN (RW), bit1 IRQ_EN (RW), bit2 FLUSH (write-1, self-clearing, always reads 0).
- Reads: on mmio_valid & ~mmio_we, mmio_rdata is registered with the selected value at the next edge. It holds its value until the next read; writes do not change it. Read latency is 1 cycle.
- Writes take effect at the edge where mmio_valid & mmio_we is sampled.
- TXDATA push when the FIFO is full: the byte is dropped, FIFO is unchanged, OVF is set.
- Simultaneous push and serializer pop on a full FIFO: the push is accepted and count stays at FIFO_DEPTH. The pop is evaluated first.
- Simultaneous OVF set and W1C in the same cycle: set wins.
- FLUSH: empties the FIFO (count=0) at the edge. A byte already in the serializer completes. A push in the same cycle as FLUSH is discarded, and OVF is not set.
- Baud tick:
  - 16-bit counter counts 0..max(BAUDDIV,1)-1 and pulses tick at wrap.
  - The counter is held at 0 in IDLE and restarts on entering START.
  - A BAUDDIV change takes effect at the next bit boundary.
- Serializer FSM:
  - IDLE: uart_tx=1. If TX_EN and the FIFO is non-empty, pop into the shift register and go to START.
  - START: uart_tx=0 for one bit time, then DATA with bit index 0.
  - DATA: uart_tx=shift[0]; shift right on each tick. After 8 bits go to STOP.
  - STOP: uart_tx=1 for one bit time, then IDLE. The next byte may start on the following cycle, giving back-to-back frames of 10 bit times.
  - Clearing TX_EN mid-frame finishes the current frame and then stalls in IDLE.
- uart_tx is driven from a flop (no glitches).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits with wrap-around. Full when the pointer MSBs differ and the lower bits are equal.
- Async reset mid-frame: uart_tx returns high immediately and all state returns to reset values.

Test Plan:
1. Reset, then read 0x4 -> mmio_rdata=0x00000002 the cycle after the request; read 0x8 -> 0x00000364.
2. Write BAUDDIV=4, CTRL=1, TXDATA=0xA5 -> uart_tx: start 0 for 4 clk, then bits 1,0,1,0,0,1,0,1 for 4 clk each, stop 1 for 4 clk. 40 clk per frame; tx_busy=1 throughout.
3. CTRL=0, push 9 bytes with FIFO_DEPTH=8 -> STATUS=0x0000_0809 (count 8, full, OVF). Write 0x4 data 0x8 -> OVF clears, STATUS=0x0801.
4. BAUDDIV=1, CTRL=1 with 3 bytes queued -> three back-to-back 10-cycle frames with no idle gap. Afterwards STATUS=0x2 and, with IRQ_EN set, tx_irq=1.
5. Mid-frame write CTRL=0x5 (TX_EN + FLUSH) with 5 queued -> current frame completes, count reads 0, no further frames.
6. Assert rst_n=0 during a DATA bit -> uart_tx=1 asynchronously, mmio_rdata=0. Read of offset 0x10 -> 0.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio
//   Transmit half of the SoC UART. The block is a memory-mapped responder. It
//   queues bytes in a TX FIFO and sends them out 8N1, LSB first, at a
//   programmable baud divisor. Software polls a status register to track the
//   FIFO and the serializer.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active-low
//   mmio_valid  single-cycle request strobe
//   mmio_we     1 = write, 0 = read (qualified by mmio_valid)
//   mmio_addr   byte offset within the peripheral window
//   mmio_wdata  write data
//   mmio_wstrb  byte enables
//   mmio_ready  always 1 out of reset
//   mmio_rdata  registered read data, valid the cycle after a read
//   uart_tx     serial output, idle high, driven from a flop
//   tx_irq      level interrupt: IRQ_EN & tx_empty & ~tx_busy
//
// Register map (addr[1:0] ignored, addr[ADDR_W-1:4] must be zero)
//   0x0 TXDATA   W   wstrb[0] pushes wdata[7:0]
//   0x4 STATUS   R   {count[15:8], OVF[3], busy[2], empty[1], full[0]}; OVF W1C
//   0x8 BAUDDIV  RW  bits[15:0]
//   0xC CTRL     RW  TX_EN[0], IRQ_EN[1], FLUSH[2] (write-1, reads 0)
// ---------------------------------------------------------------------------
module uart_tx_mmio #(
    parameter int          ADDR_W     = 12,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mmio_valid,
    input  logic              mmio_we,
    input  logic [ADDR_W-1:0] mmio_addr,
    input  logic [31:0]       mmio_wdata,
    input  logic [3:0]        mmio_wstrb,
    output logic              mmio_ready,
    output logic [31:0]       mmio_rdata,
    output logic              uart_tx,
    output logic              tx_irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // ---------------------------------------------------------------- state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [15:0]      baud_q, baud_d;
    logic             tx_en_q, tx_en_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       state_q, state_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [15:0]      cnt_q, cnt_d, bit_div_q, bit_div_d;
    logic             tx_q, tx_d;

    // --------------------------------------------------------------- decode
    logic       hit, wr_en, rd_en;
    logic [1:0] reg_sel;

    assign hit     = (mmio_addr[ADDR_W-1:4] == '0);
    assign reg_sel = mmio_addr[3:2];
    assign wr_en   = mmio_valid & mmio_we & hit;
    assign rd_en   = mmio_valid & ~mmio_we;

    logic unused_bits;
    assign unused_bits = ^{mmio_wdata[31:16], mmio_wstrb[3:2], mmio_addr[1:0]};

    // ----------------------------------------------------------------- FIFO
    logic             fifo_empty, fifo_full, tx_busy, tick;
    logic             push_req, push, pop, flush, ovf_clr;
    logic [PTR_W-1:0] count;
    logic [7:0]       fifo_rd_data;
    logic [15:0]      div_eff;

    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                          (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign fifo_rd_data = fifo_mem[rd_ptr_q[IDX_W-1:0]];
    assign tx_busy      = (state_q != ST_IDLE);

    assign push_req = wr_en & (reg_sel == REG_TXDATA) & mmio_wstrb[0];
    assign flush    = wr_en & (reg_sel == REG_CTRL) & mmio_wstrb[0] & mmio_wdata[2];
    assign ovf_clr  = wr_en & (reg_sel == REG_STATUS) & mmio_wstrb[0] & mmio_wdata[3];

    // The serializer pops from IDLE, or straight out of the last STOP cycle so
    // consecutive frames have no idle gap.
    assign pop  = tx_en_q & ~fifo_empty &
                  ((state_q == ST_IDLE) | ((state_q == ST_STOP) & tick));
    // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
    assign push = push_req & ~flush & (~fifo_full | pop);

    assign wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
    assign rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};

    // NOTE: FIFO storage has no reset; the pointers alone define which
    // entries are valid, so clearing the array would only cost flops.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[IDX_W-1:0]] <= mmio_wdata[7:0];
        end
    end

    // ------------------------------------------------------------ registers
    logic [31:0] rd_val;

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        baud_d   = baud_q;
        tx_en_d  = tx_en_q;
        irq_en_d = irq_en_q;
        if (wr_en && reg_sel == REG_BAUD) begin
            if (mmio_wstrb[0]) baud_d[7:0]  = mmio_wdata[7:0];
            if (mmio_wstrb[1]) baud_d[15:8] = mmio_wdata[15:8];
        end
        if (wr_en && reg_sel == REG_CTRL && mmio_wstrb[0]) begin
            tx_en_d  = mmio_wdata[0];
            irq_en_d = mmio_wdata[1];
        end
        // Overflow set has priority over a same-cycle clear.
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (push_req && !flush && fifo_full && !pop) ovf_d = 1'b1;

        rd_val = '0;
        if (hit) begin
            case (reg_sel)
                REG_STATUS: rd_val = {16'd0, 8'(count), 4'd0, ovf_q, tx_busy,
                                      fifo_empty, fifo_full};
                REG_BAUD:   rd_val = {16'd0, baud_q};
                REG_CTRL:   rd_val = {30'd0, irq_en_q, tx_en_q};
                default:    rd_val = '0;
            endcase
        end
        rdata_d = rd_en ? rd_val : rdata_q;
    end

    // ----------------------------------------------------------- serializer
    assign div_eff = (baud_q == 16'd0) ? 16'd1 : baud_q;
    // bit_div_q is sampled at each bit boundary, so a BAUDDIV write never
    // stretches or truncates the bit currently on the wire.
    assign tick    = tx_busy && (cnt_q == bit_div_q - 16'd1);

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        cnt_d     = (state_q == ST_IDLE || tick) ? 16'd0 : cnt_q + 16'd1;
        bit_div_d = (pop || tick) ? div_eff : bit_div_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = fifo_rd_data;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (pop) begin
                        shift_d = fifo_rd_data;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            baud_q    <= DIV_RESET;
            tx_en_q   <= 1'b0;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            bit_div_q <= 16'd1;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            baud_q    <= baud_d;
            tx_en_q   <= tx_en_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            bit_div_q <= bit_div_d;
            tx_q      <= tx_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign mmio_ready = 1'b1;
    assign mmio_rdata = rdata_q;
    assign uart_tx    = tx_q;
    assign tx_irq     = irq_en_q & fifo_empty & ~tx_busy;

endmodule
